instruction_fetch: RTL and testbench

Fetch stage of the 24-bit CPU. It owns the program counter and drives `PCAddress` into `InstructionMemory`, whose read is combinational. It captures the returned 24-bit `Instruction` into an IF/ID register and hands it to decode over a valid/ready handshake. It also supports branch/jump redirect with flush, and stops fetching on a HALT opcode.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/instruction_fetch.sv | 87 ++++++++
 tb/tb_instruction_fetch.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, instruction size, opcode field
// position, default HALT opcode and the fetch-stage state type.
package cpu_pkg;

    localparam int XLEN        = 24;
    localparam int INSTR_BYTES = 3;

    localparam int OPCODE_MSB  = 23;
    localparam int OPCODE_LSB  = 18;
    localparam int OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the external combinational instruction
// memory and registers the fetched word into the IF/ID register, which is
// presented to decode over a valid/ready handshake. Supports redirect with
// flush and stops fetching after a HALT opcode has been loaded.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0]     RESET_PC    = '0,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic            Clock,
    input  logic            Reset,
    output logic [XLEN-1:0] PCAddress,
    input  logic [XLEN-1:0] Instruction,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectTarget,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] OutInstruction,
    output logic [XLEN-1:0] OutPC,
    output logic [XLEN-1:0] OutPCPlus3
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic [XLEN-1:0] r_out_pc_plus3;

    logic [XLEN-1:0] w_pc_plus3;
    logic            w_load;
    logic            w_drain;
    logic            w_is_halt;

    // Next-state decode: when to load the IF/ID register or drain it.
    // NOTE: every signal gets a default assignment first so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        w_pc_plus3 = r_pc + XLEN'(INSTR_BYTES);
        w_load     = 1'b0;
        w_drain    = 1'b0;
        w_is_halt  = (Instruction[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
        if (!Redirect) begin
            w_load  = (r_state == FETCH_RUN) && (!r_out_valid || OutReady);
            w_drain = !w_load && r_out_valid && OutReady;
        end
    end

    // PC, fetch state and IF/ID register; priority is reset, redirect, load, drain.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pc           <= RESET_PC;
            r_state        <= FETCH_RUN;
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_pc       <= '0;
            r_out_pc_plus3 <= '0;
        end else if (Redirect) begin
            // Flush the wrong-path instruction even if decode is stalled.
            r_pc        <= RedirectTarget;
            r_state     <= FETCH_RUN;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_instr    <= Instruction;
            r_out_pc       <= r_pc;
            r_out_pc_plus3 <= w_pc_plus3;
            r_out_valid    <= 1'b1;
            r_pc           <= w_pc_plus3;
            // The HALT word itself is still handed downstream.
            if (w_is_halt) begin
                r_state <= FETCH_HALTED;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign PCAddress      = r_pc;
    assign OutValid       = r_out_valid;
    assign OutInstruction = r_out_instr;
    assign OutPC          = r_out_pc;
    assign OutPCPlus3     = r_out_pc_plus3;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a cycle-level reference model derived from the
// fetch rules is compared against the DUT every cycle, and directed literal
// checks pin the model at the interesting points of the sequence.
module tb_instruction_fetch;

    localparam logic [23:0] RST_PC = 24'd10;

    logic        Clock;
    logic        Reset;
    logic [23:0] PCAddress;
    logic [23:0] Instruction;
    logic        Redirect;
    logic [23:0] RedirectTarget;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] OutInstruction;
    logic [23:0] OutPC;
    logic [23:0] OutPCPlus3;

    logic        halt_armed;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(
        .RESET_PC    (RST_PC),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .PCAddress      (PCAddress),
        .Instruction    (Instruction),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .OutValid       (OutValid),
        .OutReady       (OutReady),
        .OutInstruction (OutInstruction),
        .OutPC          (OutPC),
        .OutPCPlus3     (OutPCPlus3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory contents: opcode is addr mod 63 (never 63), low bits are the
    // address; address 22 holds a HALT word only while halt_armed is set.
    function automatic logic [23:0] mem_word(input logic [23:0] a, input logic halt_en);
        if (halt_en && a == 24'd22) return {6'b111111, 18'h00ABC};
        return {6'(a % 24'd63), a[17:0]};
    endfunction

    always_comb Instruction = mem_word(PCAddress, halt_armed);

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the fetch stage, stepped on each rising edge.
    logic [23:0] m_pc, m_instr, m_out_pc, m_plus3, fetched;
    logic        m_valid, m_halted;
    logic        model_ok = 1'b0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_pc     = RST_PC;
            m_valid  = 1'b0;
            m_instr  = 24'd0;
            m_out_pc = 24'd0;
            m_plus3  = 24'd0;
            m_halted = 1'b0;
            model_ok = 1'b1;
        end else if (Redirect) begin
            m_pc     = RedirectTarget;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (!m_halted && (!m_valid || OutReady)) begin
            fetched  = mem_word(m_pc, halt_armed);
            m_instr  = fetched;
            m_out_pc = m_pc;
            m_plus3  = m_pc + 24'd3;
            m_pc     = m_pc + 24'd3;
            m_valid  = 1'b1;
            if (fetched[23:18] == 6'b111111) m_halted = 1'b1;
        end else if (m_valid && OutReady) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (model_ok) begin
            check("pc_addr",   PCAddress,          m_pc);
            check("out_valid", {23'd0, OutValid},  {23'd0, m_valid});
            check("out_instr", OutInstruction,     m_instr);
            check("out_pc",    OutPC,              m_out_pc);
            check("out_pc_p3", OutPCPlus3,         m_plus3);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic redirect_to(input logic [23:0] tgt);
        Redirect       = 1'b1;
        RedirectTarget = tgt;
        step(1);
        Redirect       = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Redirect = 1'b0; RedirectTarget = 24'd0;
        OutReady = 1'b1; halt_armed = 1'b0;
        step(2);
        Reset = 1'b0;

        // Reset state, then streaming.
        @(negedge Clock);
        check("lit_rst_pc",    PCAddress, 24'd10);
        check("lit_rst_valid", {23'd0, OutValid}, 24'd0);
        check("lit_rst_p3",    OutPCPlus3, 24'd0);
        step(1);
        @(negedge Clock);
        check("lit_s0_pc",    OutPC, 24'd10);
        check("lit_s0_p3",    OutPCPlus3, 24'd13);
        check("lit_s0_instr", OutInstruction, {6'd10, 18'd10});
        check("lit_s0_addr",  PCAddress, 24'd13);
        step(2);
        @(negedge Clock);
        check("lit_s2_pc", OutPC, 24'd16);

        // Backpressure for three cycles.
        OutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            @(negedge Clock);
            check("lit_bp_addr", PCAddress, 24'd19);
            check("lit_bp_pc",   OutPC, 24'd16);
        end
        OutReady = 1'b1;
        step(1);
        @(negedge Clock);
        check("lit_bp_release", OutPC, 24'd19);

        // Redirect while stalled.
        OutReady = 1'b0;
        step(1);
        redirect_to(24'd40);
        @(negedge Clock);
        check("lit_rd_valid", {23'd0, OutValid}, 24'd0);
        check("lit_rd_addr",  PCAddress, 24'd40);
        step(1);
        @(negedge Clock);
        check("lit_rd_valid2", {23'd0, OutValid}, 24'd1);
        check("lit_rd_pc",     OutPC, 24'd40);
        OutReady = 1'b1;

        // Redirect coinciding with a would-be HALT load: redirect wins.
        halt_armed = 1'b1;
        redirect_to(24'd19);
        step(1);
        redirect_to(24'd22);
        @(negedge Clock);
        check("lit_rh_valid", {23'd0, OutValid}, 24'd0);
        check("lit_rh_addr",  PCAddress, 24'd22);

        // HALT: presented, accepted, then fetch stops.
        step(1);
        @(negedge Clock);
        check("lit_h_pc",  OutPC, 24'd22);
        check("lit_h_op",  {18'd0, OutInstruction[23:18]}, 24'd63);
        step(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("lit_h_valid", {23'd0, OutValid}, 24'd0);
            check("lit_h_addr",  PCAddress, 24'd25);
            step(1);
        end

        // Redirect out of HALTED resumes streaming.
        halt_armed = 1'b0;
        redirect_to(24'd10);
        step(2);
        @(negedge Clock);
        check("lit_resume_pc", OutPC, 24'd13);

        // Wrap-around.
        redirect_to(24'hFFFFFE);
        step(1);
        @(negedge Clock);
        check("lit_wrap_pc",   OutPC, 24'hFFFFFE);
        check("lit_wrap_p3",   OutPCPlus3, 24'h000001);
        check("lit_wrap_addr", PCAddress, 24'h000001);
        step(2);

        // Reset mid-stall together with a redirect.
        OutReady = 1'b0;
        step(2);
        Reset = 1'b1; Redirect = 1'b1; RedirectTarget = 24'd40;
        step(1);
        Reset = 1'b0; Redirect = 1'b0;
        @(negedge Clock);
        check("lit_mr_valid", {23'd0, OutValid}, 24'd0);
        check("lit_mr_addr",  PCAddress, 24'd10);
        check("lit_mr_pc",    OutPC, 24'd0);
        OutReady = 1'b1;
        step(2);
        @(negedge Clock);
        check("lit_mr_run", OutPC, 24'd13);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_fetch
